// File: rtl/mips_dm_pkg.sv
// Shared types and constants for the MIPS data-memory arbiter.
package mips_dm_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StResp
    } dm_state_t;

    localparam int unsigned DM_DEPTH  = 512;
    localparam int unsigned DM_RD_LAT = 1;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/mips_dm_arb_pick.sv
// Combinational winner selection between the CPU and debug requesters.
// Build option MIPS_DM_ARB_RR_EN: round-robin on contention using ptr;
// otherwise fixed priority with the CPU port always winning.
module mips_dm_arb_pick
    import mips_dm_pkg::*;
(
    input  logic [1:0] req,
`ifdef MIPS_DM_ARB_RR_EN
    input  logic       ptr,
`endif
    output logic       any,
    output logic       win
);

    // Lone requester always wins; contention resolved by ptr or fixed priority
    always_comb begin
        any = |req;
        win = PORT_CPU;
`ifdef MIPS_DM_ARB_RR_EN
        if (req == 2'b11) begin
            win = ptr;
        end else if (req[1]) begin
            win = PORT_DBG;
        end
`else
        if (!req[0] && req[1]) begin
            win = PORT_DBG;
        end
`endif
    end

endmodule

// File: rtl/mips_dm_arbiter.sv
// Two-requester arbiter and access sequencer for the MIPS data memory.
// Build option MIPS_DM_ARB_RR_EN enables round-robin arbitration; default is
// fixed priority (port 0 wins).
module mips_dm_arbiter
    import mips_dm_pkg::*;
#(
    parameter int unsigned DEPTH  = DM_DEPTH,
    parameter int unsigned RD_LAT = DM_RD_LAT,
    parameter int unsigned AW     = 32
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [31:0]   r0_wdata,
    output logic          r0_gnt,
    output logic          r0_done,
    output logic          r0_err,
    output logic [31:0]   r0_rdata,

    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [31:0]   r1_wdata,
    output logic          r1_gnt,
    output logic          r1_done,
    output logic          r1_err,
    output logic [31:0]   r1_rdata,

    output logic          mem_read,
    output logic          mem_write,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    // Range check is done one bit wider so DEPTH == 2**AW cannot wrap
    localparam logic [AW:0] DepthExt = (AW + 1)'(DEPTH);
    localparam logic [2:0]  RdLat    = 3'(RD_LAT);

    dm_state_t     state_q, state_d;
    logic          sel_q;
    logic          we_q;
    logic          err_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    cnt_q;
    logic [1:0]    gnt_q;
    logic [31:0]   rdata0_q;
    logic [31:0]   rdata1_q;

    logic          any_req;
    logic          win;
    logic          oor;
    logic [1:0]    done_v;

`ifdef MIPS_DM_ARB_RR_EN
    logic          ptr_q;

    // Pointer moves away from whichever port just completed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= PORT_CPU;
        end else if (state_q == StResp) begin
            ptr_q <= ~sel_q;
        end
    end
`endif

    mips_dm_arb_pick u_pick (
        .req ({r1_req, r0_req}),
`ifdef MIPS_DM_ARB_RR_EN
        .ptr (ptr_q),
`endif
        .any (any_req),
        .win (win)
    );

    assign oor = {1'b0, addr_q} >= DepthExt;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and single-cycle memory strobes
    always_comb begin
        state_d   = state_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (oor) begin
                    state_d = StResp;
                end else if (we_q) begin
                    mem_write = 1'b1;
                    state_d   = StResp;
                end else begin
                    mem_read = 1'b1;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 3'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Request latches, grant, read-latency counter and returned data
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_q    <= PORT_CPU;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        sel_q   <= win;
                        err_q   <= 1'b0;
                        we_q    <= (win == PORT_DBG) ? r1_we    : r0_we;
                        addr_q  <= (win == PORT_DBG) ? r1_addr  : r0_addr;
                        wdata_q <= (win == PORT_DBG) ? r1_wdata : r0_wdata;
                        gnt_q   <= (win == PORT_DBG) ? 2'b10    : 2'b01;
                    end
                end
                StAccess: begin
                    cnt_q <= RdLat;
                    if (oor) begin
                        err_q <= 1'b1;
                        if (sel_q == PORT_DBG) begin
                            rdata1_q <= '0;
                        end else begin
                            rdata0_q <= '0;
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        if (sel_q == PORT_DBG) begin
                            rdata1_q <= mem_rdata;
                        end else begin
                            rdata0_q <= mem_rdata;
                        end
                    end
                end
                StResp: begin
                    gnt_q <= 2'b00;
                end
                default: begin
                    gnt_q <= 2'b00;
                end
            endcase
        end
    end

    assign done_v    = (state_q == StResp) ? ((sel_q == PORT_DBG) ? 2'b10 : 2'b01) : 2'b00;

    assign r0_gnt    = gnt_q[0];
    assign r1_gnt    = gnt_q[1];
    assign r0_done   = done_v[0];
    assign r1_done   = done_v[1];
    assign r0_err    = done_v[0] & err_q;
    assign r1_err    = done_v[1] & err_q;
    assign r0_rdata  = rdata0_q;
    assign r1_rdata  = rdata1_q;

    assign mem_addr  = 32'(addr_q);
    assign mem_wdata = wdata_q;

endmodule
